pc_fetch_sequencer: RTL and testbench
=====================================

# pc_fetch_sequencer

Program-counter sequencer for the IF stage. It owns the PC register and drives the instruction-memory request/acknowledge handshake. PC increments are computed by an internal 32-bit adder instance. Completed fetches are buffered in an output register plus a one-entry skid, so decode stalls never drop an instruction, and branch/jump redirects from EX discard stale fetches, including a request that is already outstanding.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- INC, 32'd4, PC increment per instruction
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  decode cannot accept; hold if_* outputs
- redirect_valid_i  in  1  taken branch/jump; flush IF and restart at target
- redirect_target_i  in  32  new PC
- imem_req_o  out  1  fetch request
- imem_addr_o  out  32  fetch address, stable while imem_req_o=1
- imem_ack_i  in  1  single-cycle accept; imem_rdata_i valid the same cycle
- imem_rdata_i  in  32  instruction word
- if_valid_o  out  1  if_* outputs hold a live instruction
- if_pc_o  out  32  PC of if_instr_o
- if_pc_inc_o  out  32  if_pc_o + INC
- if_instr_o  out  32  instruction

## Operation
- Registers:
  - pc: next address to launch.
  - req_addr: drives imem_addr_o.
  - out_* bank: drives the if_* outputs.
  - skid bank: one entry, with skid_full.
  - state.
- States:
  - IDLE: no request outstanding.
  - REQ: live request outstanding.
  - KILL: outstanding request whose response is discarded.
- imem_req_o = 1 in REQ and KILL.
- Launch action: req_addr <= A, pc <= A + INC (via adder), state <= REQ.
- Launch is permitted only if skid_full is 0 at the end of the current cycle.
- IDLE: launch pc when permitted; otherwise stay in IDLE.
- REQ, ack=1, no redirect: deliver {req_addr, req_addr+INC, rdata}.
  - Then launch pc if permitted, giving back-to-back fetches at one per cycle.
  - Otherwise go to IDLE.
- REQ, ack=0: hold req_addr; stay in REQ.
- KILL, ack=1: drop rdata; launch pc if permitted, else go to IDLE.
- KILL, ack=0: stay in KILL.
- Delivery:
  - If out is empty or stall_i=0, the output bank loads and if_valid_o <= 1.
  - Otherwise (out is full and stall_i=1), the skid loads.
- Consumption: out is consumed when stall_i=0 and if_valid_o=1.
  - Then the output bank loads from the skid if skid_full=1, else from the same-cycle delivery if any, else if_valid_o <= 0.
  - A skid-full state and a same-cycle delivery cannot coexist, because no request is outstanding while skid_full=1.
- Redirect (highest priority, overrides stall_i):
  - if_valid_o <= 0 and skid_full <= 0.
  - Any same-cycle ack data is dropped.
  - IDLE, or REQ with ack=1, or KILL with ack=1: launch redirect_target_i.
  - REQ with ack=0: pc <= target, state <= KILL.
  - KILL with ack=0: pc <= target; the newest redirect wins; stay in KILL.
- Arithmetic: 32-bit, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 with no flag.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_VECTOR, req_addr=RESET_VECTOR.
  - imem_req_o=0, if_valid_o=0, skid_full=0.
  - if_pc_o, if_pc_inc_o and if_instr_o are 0; the skid data registers are 0.
- First imem_req_o is high in the first clock edge after rst_n deasserts, with imem_addr_o=RESET_VECTOR.
- Latency: ack in cycle N gives if_valid_o=1 in cycle N+1.
- Sustained throughput: 1 instruction/cycle with an ack every cycle and stall_i=0.
- Redirect in cycle N:
  - if_valid_o=0 in N+1.
  - With no request outstanding, the target request is visible in N+1.
- stall_i is sampled only when if_valid_o=1. While it is held, the if_* outputs are stable.
- Up to 2 instructions are buffered during a stall: the output bank plus the skid.
- Reset mid-request: outputs clear immediately. The memory must abandon the request when imem_req_o drops.

## Test plan
- Reset release, ack every cycle, stall_i=0 -> imem_addr_o 0,4,8,12 on consecutive cycles; if_pc_o 0,4,8 one cycle later; if_pc_inc_o = if_pc_o+4.
- Stall for 5 cycles with acks available -> output holds PC 0x8; skid takes 0xC; imem_req_o=0 until release; release gives 0x8 then 0xC then 0x10 with no loss or duplication.
- Redirect to 0x100 while a request to 0x14 waits 3 cycles for ack -> state KILL; 0x14 data never appears on if_*; next imem_addr_o=0x100; first if_pc_o after flush = 0x100.
- Redirect to 0x200 coincident with an ack for 0x20 -> 0x20 dropped; imem_addr_o=0x200 next cycle; if_valid_o=0 for exactly that cycle.
- Redirect during a stall with the skid full -> both entries flushed; if_valid_o=0 next cycle despite stall_i=1; fetch resumes at the target.
- Redirect to 0xFFFF_FFFC -> if_pc_inc_o=0; next fetch address 0x0.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// IF-stage program-counter sequencer. Owns the PC and drives a single
// outstanding instruction-memory request. Fetched words go to an output bank.
// A one-entry skid holds one more word while decode stalls. Redirects flush
// both banks. A redirect that arrives while a request is still waiting for
// its ack marks that request as killed, so its data is discarded.
//
// Ports
//   clk                rising-edge clock
//   rst_n              asynchronous active-low reset
//   stall_i            decode cannot accept; if_* outputs hold
//   redirect_valid_i   taken branch/jump from EX
//   redirect_target_i  restart address for the redirect
//   imem_req_o         fetch request (registered)
//   imem_addr_o        fetch address, stable while imem_req_o=1
//   imem_ack_i         single-cycle accept, imem_rdata_i valid same cycle
//   imem_rdata_i       instruction word
//   if_valid_o         if_* outputs carry a live instruction
//   if_pc_o            PC of if_instr_o
//   if_pc_inc_o        if_pc_o + INC
//   if_instr_o         instruction word
// ---------------------------------------------------------------------------

// 32-bit modulo adder used for all PC increments.
module pc_fetch_adder (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  assign o_sum = i_a + i_b;
endmodule

module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INC          = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_inc_o,
  output logic [31:0] if_instr_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_KILL = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_req;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_pc_inc;
  logic [31:0] r_out_instr;
  logic        r_skid_full;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_pc_inc;
  logic [31:0] r_skid_instr;

  state_t      w_state_n;
  logic [31:0] w_pc_n;
  logic [31:0] w_req_addr_n;
  logic        w_req_n;
  logic        w_out_valid_n;
  logic [31:0] w_out_pc_n;
  logic [31:0] w_out_pc_inc_n;
  logic [31:0] w_out_instr_n;
  logic        w_skid_full_n;
  logic [31:0] w_skid_pc_n;
  logic [31:0] w_skid_pc_inc_n;
  logic [31:0] w_skid_instr_n;

  logic        w_deliver;
  logic        w_launch_ok;
  logic [31:0] w_launch_addr;
  logic [31:0] w_launch_sum;
  logic [31:0] w_req_addr_inc;

  // The redirect target replaces the sequential PC as the launch address.
  assign w_launch_addr = redirect_valid_i ? redirect_target_i : r_pc;

  // A live ack is delivered only if no redirect flushes it in the same cycle.
  // An ack in KILL never delivers.
  assign w_deliver = (r_state == ST_REQ) && imem_ack_i && !redirect_valid_i;

  pc_fetch_adder u_launch_add (
    .i_a   (w_launch_addr),
    .i_b   (INC),
    .o_sum (w_launch_sum)
  );

  pc_fetch_adder u_deliver_add (
    .i_a   (r_req_addr),
    .i_b   (INC),
    .o_sum (w_req_addr_inc)
  );

  // Next-state logic for the output bank, the skid and the fetch FSM.
  always_comb begin
    w_state_n       = r_state;
    w_pc_n          = r_pc;
    w_req_addr_n    = r_req_addr;
    w_out_valid_n   = r_out_valid;
    w_out_pc_n      = r_out_pc;
    w_out_pc_inc_n  = r_out_pc_inc;
    w_out_instr_n   = r_out_instr;
    w_skid_full_n   = r_skid_full;
    w_skid_pc_n     = r_skid_pc;
    w_skid_pc_inc_n = r_skid_pc_inc;
    w_skid_instr_n  = r_skid_instr;

    // Buffering. While the skid is full, no request is outstanding, so
    // a skid refill and a new delivery never happen in the same cycle.
    if (redirect_valid_i) begin
      w_out_valid_n = 1'b0;
      w_skid_full_n = 1'b0;
    end else if (r_out_valid && stall_i) begin
      if (w_deliver) begin
        w_skid_full_n   = 1'b1;
        w_skid_pc_n     = r_req_addr;
        w_skid_pc_inc_n = w_req_addr_inc;
        w_skid_instr_n  = imem_rdata_i;
      end else begin
        w_skid_full_n = r_skid_full;
      end
    end else if (r_out_valid) begin
      if (r_skid_full) begin
        w_out_valid_n  = 1'b1;
        w_out_pc_n     = r_skid_pc;
        w_out_pc_inc_n = r_skid_pc_inc;
        w_out_instr_n  = r_skid_instr;
        w_skid_full_n  = 1'b0;
      end else if (w_deliver) begin
        w_out_valid_n  = 1'b1;
        w_out_pc_n     = r_req_addr;
        w_out_pc_inc_n = w_req_addr_inc;
        w_out_instr_n  = imem_rdata_i;
      end else begin
        w_out_valid_n = 1'b0;
      end
    end else begin
      if (w_deliver) begin
        w_out_valid_n  = 1'b1;
        w_out_pc_n     = r_req_addr;
        w_out_pc_inc_n = w_req_addr_inc;
        w_out_instr_n  = imem_rdata_i;
      end else begin
        w_out_valid_n = 1'b0;
      end
    end

    // A new request may start only if the skid is empty after this edge.
    w_launch_ok = !w_skid_full_n;

    case (r_state)
      ST_IDLE: begin
        if (w_launch_ok) begin
          w_req_addr_n = w_launch_addr;
          w_pc_n       = w_launch_sum;
          w_state_n    = ST_REQ;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_REQ, ST_KILL: begin
        if (imem_ack_i) begin
          if (w_launch_ok) begin
            w_req_addr_n = w_launch_addr;
            w_pc_n       = w_launch_sum;
            w_state_n    = ST_REQ;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else if (redirect_valid_i) begin
          // The request stays on the bus. Its response is discarded, and the
          // newest target waits in pc.
          w_pc_n    = redirect_target_i;
          w_state_n = ST_KILL;
        end else begin
          w_state_n = r_state;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase

    w_req_n = (w_state_n != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_VECTOR;
      r_req_addr    <= RESET_VECTOR;
      r_req         <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_pc      <= 32'h0000_0000;
      r_out_pc_inc  <= 32'h0000_0000;
      r_out_instr   <= 32'h0000_0000;
      r_skid_full   <= 1'b0;
      r_skid_pc     <= 32'h0000_0000;
      r_skid_pc_inc <= 32'h0000_0000;
      r_skid_instr  <= 32'h0000_0000;
    end else begin
      r_state       <= w_state_n;
      r_pc          <= w_pc_n;
      r_req_addr    <= w_req_addr_n;
      r_req         <= w_req_n;
      r_out_valid   <= w_out_valid_n;
      r_out_pc      <= w_out_pc_n;
      r_out_pc_inc  <= w_out_pc_inc_n;
      r_out_instr   <= w_out_instr_n;
      r_skid_full   <= w_skid_full_n;
      r_skid_pc     <= w_skid_pc_n;
      r_skid_pc_inc <= w_skid_pc_inc_n;
      r_skid_instr  <= w_skid_instr_n;
    end
  end

  assign imem_req_o  = r_req;
  assign imem_addr_o = r_req_addr;
  assign if_valid_o  = r_out_valid;
  assign if_pc_o     = r_out_pc;
  assign if_pc_inc_o = r_out_pc_inc;
  assign if_instr_o  = r_out_instr;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//
// Directed bench for pc_fetch_sequencer. Inputs change on the falling edge.
// Outputs are checked on the following falling edge, after the rising edge
// has been applied. The memory returns each instruction word as
// (address ^ KEY), so every expected word is known ahead of time.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_inc_o;
  logic [31:0] if_instr_o;

  int n_total;
  int n_bad;

  pc_fetch_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_i           (stall_i),
    .redirect_valid_i  (redirect_valid_i),
    .redirect_target_i (redirect_target_i),
    .imem_req_o        (imem_req_o),
    .imem_addr_o       (imem_addr_o),
    .imem_ack_i        (imem_ack_i),
    .imem_rdata_i      (imem_rdata_i),
    .if_valid_o        (if_valid_o),
    .if_pc_o           (if_pc_o),
    .if_pc_inc_o       (if_pc_inc_o),
    .if_instr_o        (if_instr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, apply the rising edge, and return at the
  // next falling edge.
  task automatic step(input logic s, input logic a, input logic r, input logic [31:0] t);
    stall_i           = s;
    imem_ack_i        = a;
    redirect_valid_i  = r;
    redirect_target_i = t;
    imem_rdata_i      = imem_addr_o ^ KEY;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_total           = 0;
    n_bad             = 0;
    rst_n             = 1'b0;
    stall_i           = 1'b0;
    redirect_valid_i  = 1'b0;
    redirect_target_i = 32'h0;
    imem_ack_i        = 1'b0;
    imem_rdata_i      = 32'h0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_req",   {31'd0, imem_req_o}, 32'd0);
    check_val("rst_addr",  imem_addr_o, 32'h0);
    check_val("rst_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("rst_pc",    if_pc_o, 32'h0);
    check_val("rst_inc",   if_pc_inc_o, 32'h0);
    check_val("rst_instr", if_instr_o, 32'h0);
    rst_n = 1'b1;

    // Streaming, with an ack every cycle
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("e1_req",   {31'd0, imem_req_o}, 32'd1);
    check_val("e1_addr",  imem_addr_o, 32'h0);
    check_val("e1_valid", {31'd0, if_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("e2_addr",  imem_addr_o, 32'h4);
    check_val("e2_valid", {31'd0, if_valid_o}, 32'd1);
    check_val("e2_pc",    if_pc_o, 32'h0);
    check_val("e2_inc",   if_pc_inc_o, 32'h4);
    check_val("e2_instr", if_instr_o, 32'h0 ^ KEY);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("e3_addr",  imem_addr_o, 32'h8);
    check_val("e3_pc",    if_pc_o, 32'h4);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("e4_addr",  imem_addr_o, 32'hC);
    check_val("e4_pc",    if_pc_o, 32'h8);
    check_val("e4_inc",   if_pc_inc_o, 32'hC);

    // Five-cycle stall: output holds 0x8, the skid takes 0xC, requests stop
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      check_val("stall_req",   {31'd0, imem_req_o}, 32'd0);
      check_val("stall_valid", {31'd0, if_valid_o}, 32'd1);
      check_val("stall_pc",    if_pc_o, 32'h8);
      check_val("stall_instr", if_instr_o, 32'h8 ^ KEY);
    end
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("rel_pc",    if_pc_o, 32'hC);
    check_val("rel_instr", if_instr_o, 32'hC ^ KEY);
    check_val("rel_req",   {31'd0, imem_req_o}, 32'd1);
    check_val("rel_addr",  imem_addr_o, 32'h10);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("rel2_pc",   if_pc_o, 32'h10);
    check_val("rel2_addr", imem_addr_o, 32'h14);

    // Redirect to 0x100 while 0x14 waits three cycles for its ack
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("wait_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("wait_addr",  imem_addr_o, 32'h14);
    step(1'b0, 1'b0, 1'b1, 32'h100);
    check_val("kill_req",   {31'd0, imem_req_o}, 32'd1);
    check_val("kill_addr",  imem_addr_o, 32'h14);
    check_val("kill_valid", {31'd0, if_valid_o}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    check_val("kill2_addr", imem_addr_o, 32'h14);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("kill_drop_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("kill_next_addr",  imem_addr_o, 32'h100);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("tgt_valid", {31'd0, if_valid_o}, 32'd1);
    check_val("tgt_pc",    if_pc_o, 32'h100);
    check_val("tgt_instr", if_instr_o, 32'h100 ^ KEY);
    check_val("tgt_addr",  imem_addr_o, 32'h104);

    // Reach 0x20, then redirect to 0x200 in the same cycle as its ack
    step(1'b0, 1'b1, 1'b1, 32'h1C);
    check_val("r1c_addr",  imem_addr_o, 32'h1C);
    check_val("r1c_valid", {31'd0, if_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("r1c_pc",    if_pc_o, 32'h1C);
    check_val("r1c_addr2", imem_addr_o, 32'h20);
    step(1'b0, 1'b1, 1'b1, 32'h200);
    check_val("co_valid",  {31'd0, if_valid_o}, 32'd0);
    check_val("co_addr",   imem_addr_o, 32'h200);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("co_valid2", {31'd0, if_valid_o}, 32'd1);
    check_val("co_pc",     if_pc_o, 32'h200);
    check_val("co_addr2",  imem_addr_o, 32'h204);

    // Fill the skid under stall, then redirect to 0x300
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_val("sk_req", {31'd0, imem_req_o}, 32'd0);
    check_val("sk_pc",  if_pc_o, 32'h200);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    check_val("skr_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("skr_req",   {31'd0, imem_req_o}, 32'd1);
    check_val("skr_addr",  imem_addr_o, 32'h300);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_val("skr_pc",    if_pc_o, 32'h300);
    check_val("skr_v2",    {31'd0, if_valid_o}, 32'd1);
    check_val("skr_addr2", imem_addr_o, 32'h304);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    check_val("skr_hold", if_pc_o, 32'h300);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("skr_rel_pc",    if_pc_o, 32'h304);
    check_val("skr_rel_instr", if_instr_o, 32'h304 ^ KEY);
    check_val("skr_rel_addr",  imem_addr_o, 32'h308);

    // Redirect to 0xFFFF_FFFC: the increment wraps to zero
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    check_val("wrap_addr",  imem_addr_o, 32'hFFFF_FFFC);
    check_val("wrap_valid", {31'd0, if_valid_o}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("wrap_pc",    if_pc_o, 32'hFFFF_FFFC);
    check_val("wrap_inc",   if_pc_inc_o, 32'h0);
    check_val("wrap_next",  imem_addr_o, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    check_val("wrap_pc2",   if_pc_o, 32'h0);
    check_val("wrap_inc2",  if_pc_inc_o, 32'h4);
    check_val("wrap_next2", imem_addr_o, 32'h4);

    // Reset asserted mid-request: outputs clear without waiting for a clock
    rst_n = 1'b0;
    #1;
    check_val("arst_req",   {31'd0, imem_req_o}, 32'd0);
    check_val("arst_valid", {31'd0, if_valid_o}, 32'd0);
    check_val("arst_pc",    if_pc_o, 32'h0);
    check_val("arst_addr",  imem_addr_o, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
